// File: rtl/apb3_irq_timer.sv
// apb3_irq_timer: APB3 programmable interval timer driving a level interrupt.
// Define APB3_IRQ_TIMER_PRESCALER_EN to build the PRESCALE register and prescaler counter.
`timescale 1ns/1ps
module apb3_irq_timer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  io_systemClk,
  input  logic                  io_systemReset,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic                  PREADY,
  output logic [31:0]           PRDATA,
  output logic                  PSLVERROR,
  output logic                  irq
);

  // state | meaning
  // IDLE  | EN=0, COUNT frozen
  // RUN   | EN=1, COUNT decrements on every tick
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_periodic;
  logic        r_irq_en;
  logic        r_pending;
  logic [31:0] r_load;
  logic [31:0] r_count;

  logic        w_access;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_idx;
  logic        w_mapped;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_running;
  logic        w_pre_hit;
  logic        w_tick;
  logic        w_expire;
  logic [31:0] w_pre_rdata;
  logic [31:0] w_rdata;
  logic        w_unused_paddr;

  assign w_access       = PSEL & PENABLE;
  assign w_wr           = w_access & PWRITE;
  assign w_rd           = w_access & ~PWRITE;
  assign w_idx          = PADDR[4:2];
  assign w_mapped       = (w_idx <= 3'd4);
  assign w_unused_paddr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

  assign w_ctrl_wr = w_wr & (w_idx == 3'd0);
  assign w_start   = w_ctrl_wr & PWDATA[0] & (r_state == IDLE);
  assign w_tick    = w_running & w_pre_hit;
  assign w_expire  = w_tick & (r_count == 32'd0);

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // A software CTRL write overrides the one-shot self-disable on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ctrl_wr) begin
      if (PWDATA[0]) w_state_nxt = RUN;
      else           w_state_nxt = IDLE;
    end else if (w_expire && !r_periodic) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    w_running = 1'b0;
    case (r_state)
      RUN:     w_running = 1'b1;
      default: w_running = 1'b0;
    endcase
  end

`ifdef APB3_IRQ_TIMER_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_pre_cnt;

  assign w_pre_hit   = (r_pre_cnt == r_prescale);
  assign w_pre_rdata = {16'd0, r_prescale};

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      r_prescale <= 16'd0;
      r_pre_cnt  <= 16'd0;
    end else begin
      if (w_wr && (w_idx == 3'd4)) begin
        r_prescale <= PWDATA[15:0];
        r_pre_cnt  <= 16'd0;
      end else if (w_start) begin
        r_pre_cnt  <= 16'd0;
      end else if (w_running) begin
        r_pre_cnt  <= w_pre_hit ? 16'd0 : r_pre_cnt + 16'd1;
      end
    end
  end
`else
  assign w_pre_hit   = 1'b1;
  assign w_pre_rdata = 32'd0;
`endif

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      r_periodic <= 1'b0;
      r_irq_en   <= 1'b0;
      r_load     <= 32'd0;
    end else begin
      if (w_ctrl_wr) begin
        r_periodic <= PWDATA[1];
        r_irq_en   <= PWDATA[2];
      end
      if (w_wr && (w_idx == 3'd1)) r_load <= PWDATA;
    end
  end

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      r_count <= 32'd0;
    end else if (w_start) begin
      r_count <= r_load;
    end else if (w_tick) begin
      if (r_count != 32'd0) r_count <= r_count - 32'd1;
      else if (r_periodic)  r_count <= r_load;
      else                  r_count <= 32'd0;
    end
  end

  // Expiry has priority over a same-edge W1C so no event is lost.
  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      r_pending <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
    end else if (w_wr && (w_idx == 3'd3) && PWDATA[0]) begin
      r_pending <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (w_idx)
        3'd0:    w_rdata = {29'd0, r_irq_en, r_periodic, w_running};
        3'd1:    w_rdata = r_load;
        3'd2:    w_rdata = r_count;
        3'd3:    w_rdata = {31'd0, r_pending};
        3'd4:    w_rdata = w_pre_rdata;
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign PREADY    = 1'b1;
  assign PRDATA    = w_rdata;
  assign PSLVERROR = w_access & ~w_mapped;
  assign irq       = r_pending & r_irq_en;

endmodule

// File: tb/tb_apb3_irq_timer.sv
// tb_apb3_irq_timer: directed and randomized checks of apb3_irq_timer against
// expiry times computed arithmetically from LOAD and PRESCALE.
`timescale 1ns/1ps
module tb_apb3_irq_timer;
`ifdef APB3_IRQ_TIMER_PRESCALER_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif

  localparam logic [15:0] A_CTRL = 16'h00, A_LOAD = 16'h04, A_COUNT = 16'h08,
                          A_STAT = 16'h0C, A_PRE  = 16'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic        PREADY, PSLVERROR, irq;
  logic [31:0] PRDATA;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  apb3_irq_timer #(.ADDR_WIDTH(16)) dut (
    .io_systemClk(clk), .io_systemReset(rst),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERROR(PSLVERROR), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commit edge is the second rising edge after the call when called just after an edge.
  task automatic apb_write(input logic [15:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 err = PSLVERROR;
    check("prdata_during_write", PRDATA, 32'd0);
    @(posedge clk);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 data = PRDATA; err = PSLVERROR;
    @(posedge clk);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int at, output logic ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (irq) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er, ok;
    int at, prev, t0, c0, c1, c2, L, P, T;
    logic [15:0] bad_addr [3];
    bad_addr[0] = 16'h14; bad_addr[1] = 16'h18; bad_addr[2] = 16'h1C;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_irq", irq, 1'b0);
    check("rst_pready", PREADY, 1'b1);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", PSLVERROR, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-run
    apb_write(A_LOAD, 32'd5, er);
    apb_write(A_CTRL, 32'h7, er);
    wait_irq(50, at, ok);
    check("midrun_irq_seen", ok, 1'b1);
    #2 rst = 1'b1;
    #1 check("midrun_irq_async", irq, 1'b0);
    apb_read(A_CTRL, rd, er);  check("midrun_ctrl", rd, 32'd0);
    apb_read(A_COUNT, rd, er); check("midrun_count", rd, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    apb_read(A_CTRL, rd, er);  check("post_rst_ctrl", rd, 32'd0);
    apb_read(A_LOAD, rd, er);  check("post_rst_load", rd, 32'd0);
    apb_read(A_COUNT, rd, er); check("post_rst_count", rd, 32'd0);
    apb_read(A_STAT, rd, er);  check("post_rst_status", rd, 32'd0);
    apb_read(A_PRE, rd, er);   check("post_rst_prescale", rd, 32'd0);

    // PRESCALE presence
    apb_write(A_PRE, 32'hFFFF, er);
    check("pre_wr_err", er, 1'b0);
    apb_read(A_PRE, rd, er);
    check("pre_rd_err", er, 1'b0);
    check("pre_rd_val", rd, PRESC_EN ? 32'hFFFF : 32'd0);
    apb_write(A_PRE, 32'd0, er);

    // One-shot runs: first is the directed LOAD=3/PRESCALE=0 case
    for (int i = 0; i < 6; i++) begin
      L = (i == 0) ? 3 : (i == 1) ? 1 : int'($urandom_range(0, 6));
      P = (PRESC_EN && i > 1) ? int'($urandom_range(0, 3)) : 0;
      apb_write(A_PRE, P, er);
      apb_write(A_LOAD, L, er);
      apb_write(A_CTRL, 32'h5, er);
      t0 = cyc;
      wait_irq(200, at, ok);
      check("oneshot_irq_seen", ok, 1'b1);
      check("oneshot_latency", at - t0, (L + 1) * (P + 1));
      apb_read(A_CTRL, rd, er);  check("oneshot_ctrl", rd, 32'h4);
      apb_read(A_COUNT, rd, er); check("oneshot_count", rd, 32'd0);
      apb_read(A_STAT, rd, er);  check("oneshot_status", rd, 32'd1);
      apb_write(A_STAT, 32'h1, er);
      check("w1c_irq_low", irq, 1'b0);
      apb_read(A_STAT, rd, er);  check("w1c_status", rd, 32'd0);
    end

    // COUNT is read-only and raises no error
    apb_write(A_COUNT, 32'h1234, er);
    check("count_wr_err", er, 1'b0);
    apb_read(A_COUNT, rd, er);
    check("count_wr_ignored", rd, 32'd0);

    // Periodic over 10 periods
    P = PRESC_EN ? 1 : 0;
    L = PRESC_EN ? 2 : 5;
    T = (L + 1) * (P + 1);
    apb_write(A_PRE, P, er);
    apb_write(A_LOAD, L, er);
    apb_write(A_CTRL, 32'h7, er);
    prev = cyc;
    for (int k = 0; k < 10; k++) begin
      wait_irq(100, at, ok);
      check("periodic_irq_seen", ok, 1'b1);
      check("periodic_interval", at - prev, T);
      prev = at;
      apb_write(A_STAT, 32'h1, er);
    end

    // W1C on the exact expiry edge: set wins
    wait_irq(100, at, ok);
    check("sim_irq_seen", ok, 1'b1);
    while (cyc < at + T - 2) begin @(posedge clk); #1; end
    apb_write(A_STAT, 32'h1, er);
    check("sim_w1c_irq", irq, 1'b1);
    apb_read(A_STAT, rd, er);
    check("sim_w1c_status", rd, 32'd1);

    // LOAD changed mid-run takes effect at the next reload
    apb_write(A_STAT, 32'h1, er);
    wait_irq(100, c0, ok);
    check("ld_irq0_seen", ok, 1'b1);
    apb_write(A_LOAD, 32'd9, er);
    apb_write(A_STAT, 32'h1, er);
    wait_irq(100, c1, ok);
    check("ld_irq1_seen", ok, 1'b1);
    check("ld_current_period", c1 - c0, T);
    apb_write(A_STAT, 32'h1, er);
    wait_irq(200, c2, ok);
    check("ld_irq2_seen", ok, 1'b1);
    check("ld_next_period", c2 - c1, 10 * (P + 1));
    apb_write(A_CTRL, 32'h6, er);
    apb_read(A_CTRL, rd, er);
    check("stop_ctrl", rd, 32'h6);

    // Unmapped offsets
    for (int j = 0; j < 3; j++) begin
      apb_read(bad_addr[j], rd, er);
      check("unmapped_rd_err", er, 1'b1);
      check("unmapped_rd_data", rd, 32'd0);
      apb_write(bad_addr[j], 32'hFFFF_FFFF, er);
      check("unmapped_wr_err", er, 1'b1);
    end
    apb_read(A_CTRL, rd, er); check("unmapped_ctrl_kept", rd, 32'h6);
    check("mapped_rd_err", er, 1'b0);
    apb_read(A_LOAD, rd, er); check("unmapped_load_kept", rd, 32'd9);
    apb_read(A_STAT, rd, er); check("unmapped_status_kept", rd, 32'd1);
    apb_read(A_PRE, rd, er);  check("unmapped_pre_kept", rd, PRESC_EN ? P : 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
